// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants and types for the memory stage
//
// Purpose: data width, funct3 encodings for load/store sizes and the
// memory-stage FSM state encoding, shared by mem_access and lsu_align.
// Ports: none (package).

package mem_access_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/mem_access_lsu_align.sv
// rtl/mem_access_lsu_align.sv - byte-lane alignment for loads and stores
//
// Purpose: combinational lane logic. Produces byte enables and lane-replicated
// store data, extracts and sign/zero-extends load data, and flags misaligned
// halfword/word accesses and illegal size encodings.
// Ports:
//   addr_lo_i  in  2     low address bits
//   funct3_i   in  3     access size / signedness
//   wdata_i    in  XLEN  raw store data
//   rdata_i    in  XLEN  raw bus read data
//   be_o       out 4     byte enables
//   wdata_o    out XLEN  lane-replicated store data
//   rdata_o    out XLEN  extracted, extended load data
//   misalign_o out 1     halfword/word access not naturally aligned
//   legal_o    out 1     funct3 is a valid load/store size

module lsu_align
  import mem_access_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            legal_o
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte/halfword down to bit 0 before extension.
  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = shifted;
    misalign_o = 1'b0;
    legal_o    = 1'b1;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (funct3_i == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'd0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (funct3_i == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'd0, shifted[15:0]};
        misalign_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o       = 4'b1111;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - rv32im memory stage with req/gnt/rvalid data bus
//
// Purpose: accepts one instruction from execute in IDLE, runs loads/stores
// on the data bus, returns extended load data and passes rd/csr writeback
// fields through. Stalls the pipeline while a bus access is outstanding.
// Ports:
//   clk_i, rst_ni                          clock, sync active-low reset
//   valid_i                                new instruction from execute
//   rd_addr_i/rd_we_i/rd_data_i            destination, enable, ALU/store data
//   mem_addr_i/mem_re_i/mem_we_i/opfunc3_i memory request
//   csr_addr_i/csr_data_i/csr_we_i         CSR writeback, passed through
//   dbus_gnt_i/dbus_rvalid_i/dbus_rdata_i  bus response side
//   dbus_req_o/dbus_we_o/dbus_addr_o       bus request side
//   dbus_be_o/dbus_wdata_o                 byte enables, write data
//   rd_*_o, csr_*_o                        writeback outputs
//   mem_stall_o                            pipeline freeze (combinational)
//   misalign_o/badaddr_o                   misaligned-access pulse + address

module mem_access
  import mem_access_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      opfunc3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            csr_we_i,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic            csr_we_o,
  output logic            mem_stall_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] badaddr_o
);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            dbus_we_q, dbus_we_d;
  logic [XLEN-1:0] dbus_addr_q, dbus_addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_we_q, rd_we_d;
  logic [11:0]     csr_addr_q, csr_addr_d;
  logic [XLEN-1:0] csr_data_q, csr_data_d;
  logic            csr_we_q, csr_we_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;

  // Fields captured at acceptance, held until the bus access completes.
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [2:0]      f3_q, f3_d;
  logic            is_load_q, is_load_d;
  logic [4:0]      cap_rd_addr_q, cap_rd_addr_d;
  logic            cap_rd_we_q, cap_rd_we_d;
  logic [11:0]     cap_csr_addr_q, cap_csr_addr_d;
  logic [XLEN-1:0] cap_csr_data_q, cap_csr_data_d;
  logic            cap_csr_we_q, cap_csr_we_d;

  logic            idle;
  logic            mem_op;
  logic [1:0]      al_addr;
  logic [2:0]      al_f3;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_misalign;
  logic            al_legal;
  logic            start;

  assign idle   = (state_q == ST_IDLE);
  assign mem_op = mem_re_i | mem_we_i;

  // One aligner serves both phases: in IDLE it sees the incoming request
  // (store lanes, misalign check); otherwise the captured address/size
  // (load extraction at completion).
  assign al_addr = idle ? mem_addr_i[1:0] : addr_lo_q;
  assign al_f3   = idle ? opfunc3_i : f3_q;

  lsu_align u_align (
    .addr_lo_i  (al_addr),
    .funct3_i   (al_f3),
    .wdata_i    (rd_data_i),
    .rdata_i    (dbus_rdata_i),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign),
    .legal_o    (al_legal)
  );

  assign start = idle & valid_i & mem_op & al_legal & ~al_misalign;

  assign mem_stall_o = start | (state_q == ST_REQ) |
                       ((state_q == ST_WAIT) & ~dbus_rvalid_i);

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    dbus_we_d      = dbus_we_q;
    dbus_addr_d    = dbus_addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    rd_addr_d      = rd_addr_q;
    rd_data_d      = rd_data_q;
    rd_we_d        = 1'b0;
    csr_addr_d     = csr_addr_q;
    csr_data_d     = csr_data_q;
    csr_we_d       = 1'b0;
    misalign_d     = 1'b0;
    badaddr_d      = badaddr_q;
    addr_lo_d      = addr_lo_q;
    f3_d           = f3_q;
    is_load_d      = is_load_q;
    cap_rd_addr_d  = cap_rd_addr_q;
    cap_rd_we_d    = cap_rd_we_q;
    cap_csr_addr_d = cap_csr_addr_q;
    cap_csr_data_d = cap_csr_data_q;
    cap_csr_we_d   = cap_csr_we_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (!mem_op) begin
            rd_addr_d  = rd_addr_i;
            rd_data_d  = rd_data_i;
            rd_we_d    = rd_we_i;
            csr_addr_d = csr_addr_i;
            csr_data_d = csr_data_i;
            csr_we_d   = csr_we_i;
          end else if (!al_legal) begin
            // Reserved size encoding: retire as a bubble.
          end else if (al_misalign) begin
            misalign_d = 1'b1;
            badaddr_d  = mem_addr_i;
          end else begin
            state_d        = ST_REQ;
            req_d          = 1'b1;
            dbus_we_d      = mem_we_i;
            dbus_addr_d    = {mem_addr_i[XLEN-1:2], 2'b00};
            be_d           = al_be;
            wdata_d        = al_wdata;
            addr_lo_d      = mem_addr_i[1:0];
            f3_d           = opfunc3_i;
            is_load_d      = ~mem_we_i;
            cap_rd_addr_d  = rd_addr_i;
            cap_rd_we_d    = rd_we_i;
            cap_csr_addr_d = csr_addr_i;
            cap_csr_data_d = csr_data_i;
            cap_csr_we_d   = csr_we_i;
          end
        end
      end
      ST_REQ: begin
        if (dbus_gnt_i) begin
          state_d = ST_WAIT;
          req_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dbus_rvalid_i) begin
          state_d    = ST_IDLE;
          rd_addr_d  = cap_rd_addr_q;
          csr_addr_d = cap_csr_addr_q;
          csr_data_d = cap_csr_data_q;
          csr_we_d   = cap_csr_we_q;
          if (is_load_q) begin
            rd_data_d = al_rdata;
            rd_we_d   = cap_rd_we_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      req_q          <= 1'b0;
      dbus_we_q      <= 1'b0;
      dbus_addr_q    <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
      rd_we_q        <= 1'b0;
      csr_addr_q     <= '0;
      csr_data_q     <= '0;
      csr_we_q       <= 1'b0;
      misalign_q     <= 1'b0;
      badaddr_q      <= '0;
      addr_lo_q      <= '0;
      f3_q           <= '0;
      is_load_q      <= 1'b0;
      cap_rd_addr_q  <= '0;
      cap_rd_we_q    <= 1'b0;
      cap_csr_addr_q <= '0;
      cap_csr_data_q <= '0;
      cap_csr_we_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      dbus_we_q      <= dbus_we_d;
      dbus_addr_q    <= dbus_addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      rd_we_q        <= rd_we_d;
      csr_addr_q     <= csr_addr_d;
      csr_data_q     <= csr_data_d;
      csr_we_q       <= csr_we_d;
      misalign_q     <= misalign_d;
      badaddr_q      <= badaddr_d;
      addr_lo_q      <= addr_lo_d;
      f3_q           <= f3_d;
      is_load_q      <= is_load_d;
      cap_rd_addr_q  <= cap_rd_addr_d;
      cap_rd_we_q    <= cap_rd_we_d;
      cap_csr_addr_q <= cap_csr_addr_d;
      cap_csr_data_q <= cap_csr_data_d;
      cap_csr_we_q   <= cap_csr_we_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign rd_we_o      = rd_we_q;
  assign csr_addr_o   = csr_addr_q;
  assign csr_data_o   = csr_data_q;
  assign csr_we_o     = csr_we_q;
  assign misalign_o   = misalign_q;
  assign badaddr_o    = badaddr_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access

module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic [31:0] rd_data_i;
  logic [31:0] mem_addr_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [2:0]  opfunc3_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_data_i;
  logic        csr_we_i;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_data_o;
  logic        csr_we_o;
  logic        mem_stall_o;
  logic        misalign_o;
  logic [31:0] badaddr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_access dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .rd_addr_i     (rd_addr_i),
    .rd_we_i       (rd_we_i),
    .rd_data_i     (rd_data_i),
    .mem_addr_i    (mem_addr_i),
    .mem_re_i      (mem_re_i),
    .mem_we_i      (mem_we_i),
    .opfunc3_i     (opfunc3_i),
    .csr_addr_i    (csr_addr_i),
    .csr_data_i    (csr_data_i),
    .csr_we_i      (csr_we_i),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .rd_we_o       (rd_we_o),
    .csr_addr_o    (csr_addr_o),
    .csr_data_o    (csr_data_o),
    .csr_we_o      (csr_we_o),
    .mem_stall_o   (mem_stall_o),
    .misalign_o    (misalign_o),
    .badaddr_o     (badaddr_o)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          gd;
    logic        acc;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        rd_we;
    logic        mis;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0; rd_we_i = 1'b0;
    csr_we_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int st;
    st = 0;
    valid_i = 1'b1; mem_re_i = v.re; mem_we_i = v.we; opfunc3_i = v.f3;
    mem_addr_i = v.addr; rd_data_i = v.data; rd_addr_i = 5'(idx + 1);
    rd_we_i = v.re; csr_we_i = 1'b0;
    @(negedge clk_i);
    chk($sformatf("v%0d_stall_c0", idx), 32'(mem_stall_o), 32'(v.acc));
    if (mem_stall_o) st++;
    step();
    idle_inputs();
    if (v.acc) begin
      chk($sformatf("v%0d_req", idx), 32'(dbus_req_o), 32'd1);
      chk($sformatf("v%0d_addr", idx), dbus_addr_o, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_be", idx), 32'(dbus_be_o), 32'(v.be));
      chk($sformatf("v%0d_we", idx), 32'(dbus_we_o), 32'(v.we));
      if (v.we) chk($sformatf("v%0d_wdata", idx), dbus_wdata_o, v.wdata);
      for (int k = 0; k < v.gd; k++) begin
        @(negedge clk_i);
        if (mem_stall_o) st++;
        chk($sformatf("v%0d_hold_req%0d", idx, k), 32'(dbus_req_o), 32'd1);
        chk($sformatf("v%0d_hold_be%0d", idx, k),
            {dbus_be_o, dbus_addr_o[27:0]}, {v.be, 26'(v.addr[27:2]), 2'b00});
        step();
      end
      dbus_gnt_i = 1'b1;
      @(negedge clk_i);
      if (mem_stall_o) st++;
      step();
      dbus_gnt_i = 1'b0;
      chk($sformatf("v%0d_req_drop", idx), 32'(dbus_req_o), 32'd0);
      dbus_rvalid_i = 1'b1; dbus_rdata_i = v.rdata;
      @(negedge clk_i);
      chk($sformatf("v%0d_stall_rvalid", idx), 32'(mem_stall_o), 32'd0);
      step();
      dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
      chk($sformatf("v%0d_stall_cycles", idx), 32'(st), 32'(2 + v.gd));
      chk($sformatf("v%0d_rd_we", idx), 32'(rd_we_o), 32'(v.rd_we));
      if (v.rd_we) begin
        chk($sformatf("v%0d_rd_data", idx), rd_data_o, v.rd);
        chk($sformatf("v%0d_rd_addr", idx), 32'(rd_addr_o), 32'(idx + 1));
      end
    end else begin
      chk($sformatf("v%0d_noreq", idx), 32'(dbus_req_o), 32'd0);
      chk($sformatf("v%0d_misalign", idx), 32'(misalign_o), 32'(v.mis));
      chk($sformatf("v%0d_rd_we0", idx), 32'(rd_we_o), 32'd0);
      if (v.mis) chk($sformatf("v%0d_badaddr", idx), badaddr_o, v.addr);
      step();
      chk($sformatf("v%0d_misalign_drop", idx), 32'(misalign_o), 32'd0);
    end
  endtask

  initial begin
    //          re    we    f3      addr          data          rdata         gd acc be       wdata         rd            rdwe  mis
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1'b1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1'b1, 4'b1000, 32'h0,        32'h0000_0080, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 0, 1'b1, 4'b1100, 32'h0,        32'h0000_80FF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 1, 1'b1, 4'b1100, 32'h0,        32'hFFFF_80FF, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 32'h5555_5555, 0, 1'b1, 4'b1100, 32'hCDEF_CDEF, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        2, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0301, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0302, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'b101, 32'h0000_0203, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h0123_4567, 5, 1'b1, 4'b1111, 32'h0,        32'h0123_4567, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'hAAAA_8001, 0, 1'b1, 4'b0011, 32'h0,        32'h0000_8001, 1'b1, 1'b0};

    rst_ni = 1'b0;
    idle_inputs();
    rd_addr_i = '0; rd_data_i = '0; mem_addr_i = '0; opfunc3_i = '0;
    csr_addr_i = '0; csr_data_i = '0; dbus_rdata_i = '0;
    repeat (3) step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_rd", {rd_we_o, csr_we_o, misalign_o, dbus_we_o, 28'(rd_addr_o)}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_badaddr", badaddr_o, 32'd0);
    chk("rst_csr", csr_data_o | 32'(csr_addr_o) | dbus_addr_o | dbus_wdata_o | 32'(dbus_be_o), 32'd0);
    step();

    // Non-memory pass-through
    valid_i = 1'b1; rd_addr_i = 5'd9; rd_we_i = 1'b1; rd_data_i = 32'h0000_0055;
    csr_addr_i = 12'h300; csr_data_i = 32'h0000_0099; csr_we_i = 1'b1;
    @(negedge clk_i);
    chk("nm_stall", 32'(mem_stall_o), 32'd0);
    step();
    idle_inputs();
    chk("nm_rd_we", 32'(rd_we_o), 32'd1);
    chk("nm_rd", {rd_data_o[26:0], rd_addr_o}, {27'h55, 5'd9});
    chk("nm_csr_we", 32'(csr_we_o), 32'd1);
    chk("nm_csr", {csr_addr_o, csr_data_o[19:0]}, {12'h300, 20'h99});
    step();
    chk("nm_we_drop", {30'd0, rd_we_o, csr_we_o}, 32'd0);
    chk("nm_hold", rd_data_o, 32'h55);

    // Table vectors, issued back-to-back
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reserved funct3 on a load: bubble, no flag, no stall
    valid_i = 1'b1; mem_re_i = 1'b1; opfunc3_i = 3'b011; mem_addr_i = 32'h100; rd_we_i = 1'b1;
    @(negedge clk_i);
    chk("ill_stall", 32'(mem_stall_o), 32'd0);
    step();
    idle_inputs();
    chk("ill_noreq", {29'd0, dbus_req_o, misalign_o, rd_we_o}, 32'd0);

    // Stray gnt/rvalid in IDLE
    dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    chk("stray_stall", 32'(mem_stall_o), 32'd0);
    step();
    idle_inputs();
    chk("stray_out", {30'd0, dbus_req_o, rd_we_o}, 32'd0);

    // Reset while WAIT, then a late rvalid
    valid_i = 1'b1; mem_re_i = 1'b1; opfunc3_i = 3'b010; mem_addr_i = 32'h500; rd_we_i = 1'b1;
    rd_addr_i = 5'd3;
    step();
    idle_inputs();
    dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rw_wait_stall", 32'(mem_stall_o), 32'd1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("rw_stall", 32'(mem_stall_o), 32'd0);
    chk("rw_out", {30'd0, dbus_req_o, rd_we_o}, 32'd0);
    chk("rw_rd_data", rd_data_o, 32'd0);
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    chk("rw_late_rvalid", {30'd0, rd_we_o, dbus_req_o}, 32'd0);
    chk("rw_late_data", rd_data_o, 32'd0);
    run_vec(vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the rv32im pipeline, downstream of the execute stage. Takes the registered load/store request from execute, runs it on the data bus with a req/gnt/rvalid handshake, and produces byte-lane enables, replicated store data, and a sign- or zero-extended load result. It forwards register and CSR writeback fields to writeback and requests a pipeline stall while a bus access is outstanding.

## Interface
- XLEN, 32 (from `defines.v`), data and address width
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- valid_i  in  1  from pipectrl: execute outputs hold a new instruction this cycle, one pulse per instruction
- rd_addr_i / rd_we_i  in  5 / 1  destination register and its write enable
- rd_data_i  in  XLEN  ALU result; for stores, the store data
- mem_addr_i  in  XLEN  byte address
- mem_re_i / mem_we_i  in  1 / 1  load / store
- opfunc3_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- csr_addr_i / csr_data_i / csr_we_i  in  12 / XLEN / 1  CSR writeback, passed through
- dbus_gnt_i / dbus_rvalid_i  in  1 / 1  bus grant / response valid (loads and stores)
- dbus_rdata_i  in  XLEN  read data, valid with rvalid
- dbus_req_o / dbus_we_o  out  1 / 1  request / write
- dbus_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dbus_be_o / dbus_wdata_o  out  4 / XLEN  byte enables / lane-replicated write data
- rd_addr_o / rd_data_o / rd_we_o  out  5 / XLEN / 1  to writeback and forwarding
- csr_addr_o / csr_data_o / csr_we_o  out  12 / XLEN / 1  to writeback
- mem_stall_o  out  1  to pipectrl: freeze execute and upstream stages
- misalign_o / badaddr_o  out  1 / XLEN  one-cycle misaligned-access flag and the faulting address

## Operation
- FSM states are IDLE, REQ, WAIT. An instruction is accepted only in IDLE with valid_i=1; all fields are captured at acceptance.
- Non-memory instruction: registered pass-through of rd_* and csr_* in 1 cycle.
- Memory op, aligned: IDLE→REQ with dbus_req_o=1 registered. REQ→WAIT on gnt; req drops. WAIT→IDLE on rvalid, and writeback registers load at that edge.
- Misaligned access (H/HU with addr[0]=1, or W with addr[1:0]≠0): no bus request. misalign_o=1 and badaddr_o=addr for one cycle; rd_we_o=0.
- opfunc3 values 011, 110, 111 on a memory op: no access and a bubble; no flag.
- Byte enables: B gives 0001<<addr[1:0]; H gives 0011<<{addr[1],1'b0}; W gives 1111.
- Write data: B is {4{d[7:0]}}, H is {2{d[15:0]}}, W is d.
- Load data: shift rdata right by addr[1:0]*8, then sign-extend (B, H) or zero-extend (BU, HU).
- Stores complete on rvalid with rd_we_o=0; rdata is ignored.
- Cycles with no completion: rd_we_o=0 and csr_we_o=0; other outputs hold.
- rvalid or gnt arriving in IDLE is ignored.

## Timing
- Reset: state IDLE; every output is 0, including dbus_req_o, mem_stall_o, misalign_o, badaddr_o and all rd_*/csr_* outputs.
- Reset mid-access drops req at once. A later stray rvalid is ignored.
- mem_stall_o = (IDLE & valid_i & (re|we) & aligned & legal funct3) | REQ | (WAIT & !rvalid). It is combinational.
- Best-case load: accept in c0, req in c1 with gnt in c1, rvalid in c2, rd_data_o visible in c3. mem_stall_o is high in c0–c1 and low in c2.
- gnt may stay low indefinitely; REQ holds addr/be/wdata/we stable. rvalid comes at least 1 cycle after gnt.
- Back-to-back: a valid_i in the cycle after completion is accepted.

## Structure
- Add to `defines.v`: funct3 constants for B/H/W/BU/HU and 2-bit state encodings.
- Sub-module `lsu_align` (combinational): be/wdata generation, load extract/extend, misalign detect.

## Test plan
- LW to 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF → rd_data_o=0xDEADBEEF in c3; stall high for exactly 2 cycles.
- LB 0x103 with rdata 0x80FFFFFF → rd_data_o=0xFFFFFF80. LBU same → 0x00000080. LHU 0x102 → 0x000080FF.
- SB 0x201, data 0x000000AB → be=0010, wdata=0xABABABAB, addr=0x200, we=1; rd_we_o=0.
- LH 0x301 → no req, misalign_o pulse, badaddr_o=0x301, rd_we_o=0, no stall.
- gnt held low 5 cycles → req and fields stable, stall high throughout; completes normally afterwards.
- rst_ni low in WAIT, then rvalid after reset release → outputs 0, no writeback, FSM in IDLE.
